// File: rtl/ntt_butterfly_net.sv
// Three-stage pipelined radix-2 DIT NTT butterfly network over Z_q.
// Runs as one 8-point transform (mode=0) or two independent 4-point
// transforms on lanes 0-3 and 4-7 (mode=1). Bit-reversed in, natural out.
module ntt_butterfly_net #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_LANES = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    input  logic                              mode,
    input  logic [DATA_W-1:0]                 mod,
    input  logic [(NUM_LANES/2)*DATA_W-1:0]   omegas,
    input  logic [NUM_LANES*DATA_W-1:0]       data_in,
    output logic                              out_valid,
    output logic [NUM_LANES*DATA_W-1:0]       data_out
);

    localparam int unsigned W     = DATA_W;
    localparam int unsigned PW    = 2 * DATA_W;
    localparam int unsigned VEC_W = NUM_LANES * DATA_W;
    localparam int unsigned TW_W  = (NUM_LANES / 2) * DATA_W;
    localparam int unsigned HALF  = NUM_LANES / 2;
    localparam int unsigned QUART = NUM_LANES / 4;

    // Per-sample context: modulus, twiddles and mode travel with the data.
    typedef struct packed {
        logic             mode;
        logic [W-1:0]     q;
        logic [TW_W-1:0]  w;
        logic [VEC_W-1:0] d;
    } ctx_t;

    logic             s1_vld_q, s2_vld_q, s3_vld_q;
    ctx_t             s1_d, s1_q;
    ctx_t             s2_d, s2_q;
    logic [VEC_W-1:0] s3_data_d, s3_data_q;

    // Butterfly: returns {b', a'}. Moduli below 2 force both outputs to zero;
    // a dummy divisor keeps the remainder operators well defined in that case.
    function automatic logic [2*W-1:0] bfly(input logic [W-1:0] a,
                                            input logic [W-1:0] b,
                                            input logic [W-1:0] w,
                                            input logic [W-1:0] q);
        logic [PW-1:0] prod;
        logic [W-1:0]  qs;
        logic [W-1:0]  t;
        logic [W-1:0]  a_r;
        logic [W:0]    sum;
        logic [W:0]    dif;
        qs   = (q < W'(2)) ? W'(2) : q;
        prod = PW'(w) * PW'(b);
        t    = W'(prod % PW'(qs));
        a_r  = a % qs;
        sum  = {1'b0, a_r} + {1'b0, t};
        if (sum >= {1'b0, qs}) begin
            sum = sum - {1'b0, qs};
        end
        dif = {1'b0, a_r} - {1'b0, t};
        if (a_r < t) begin
            dif = dif + {1'b0, qs};
        end
        bfly = {dif[W-1:0], sum[W-1:0]};
        if (q < W'(2)) begin
            bfly = '0;
        end
    endfunction

    // Stage 1: adjacent pairs, all with w[0].
    always_comb begin
        logic [2*W-1:0] r1;
        r1        = '0;
        s1_d.mode = mode;
        s1_d.q    = mod;
        s1_d.w    = omegas;
        s1_d.d    = data_in;
        for (int unsigned p = 0; p < HALF; p++) begin
            r1 = bfly(data_in[W*(2*p) +: W], data_in[W*(2*p+1) +: W],
                      omegas[0 +: W], mod);
            s1_d.d[W*(2*p)   +: W] = r1[W-1:0];
            s1_d.d[W*(2*p+1) +: W] = r1[2*W-1:W];
        end
    end

    // Stage 2: distance-2 pairs inside each half; odd offset uses w[2].
    always_comb begin
        logic [2*W-1:0] r2;
        logic [W-1:0]   tw2;
        int unsigned    lo;
        r2   = '0;
        tw2  = '0;
        lo   = 0;
        s2_d = s1_q;
        for (int unsigned g = 0; g < 2; g++) begin
            for (int unsigned j = 0; j < 2; j++) begin
                lo  = g * HALF + j;
                tw2 = s1_q.w[W*(j*QUART) +: W];
                r2  = bfly(s1_q.d[W*lo +: W], s1_q.d[W*(lo+2) +: W], tw2, s1_q.q);
                s2_d.d[W*lo     +: W] = r2[W-1:0];
                s2_d.d[W*(lo+2) +: W] = r2[2*W-1:W];
            end
        end
    end

    // Stage 3: distance-4 pairs with w[i] in 8-point mode, bypass in dual mode.
    always_comb begin
        logic [2*W-1:0] r3;
        r3        = '0;
        s3_data_d = s2_q.d;
        if (!s2_q.mode) begin
            for (int unsigned i = 0; i < HALF; i++) begin
                r3 = bfly(s2_q.d[W*i +: W], s2_q.d[W*(i+HALF) +: W],
                          s2_q.w[W*i +: W], s2_q.q);
                s3_data_d[W*i        +: W] = r3[W-1:0];
                s3_data_d[W*(i+HALF) +: W] = r3[2*W-1:W];
            end
        end
    end

    // Pipeline registers: valid always advances, payload loads only on valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s3_vld_q  <= 1'b0;
            s1_q      <= '0;
            s2_q      <= '0;
            s3_data_q <= '0;
        end else begin
            s1_vld_q <= in_valid;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
            if (in_valid) begin
                s1_q <= s1_d;
            end
            if (s1_vld_q) begin
                s2_q <= s2_d;
            end
            if (s2_vld_q) begin
                s3_data_q <= s3_data_d;
            end
        end
    end

    assign out_valid = s3_vld_q;
    assign data_out  = s3_data_q;

endmodule

// File: tb/tb_ntt_butterfly_net.sv
// Scoreboard bench for ntt_butterfly_net: known vectors plus random
// transforms checked against a direct O(n^2) NTT reference.
module tb_ntt_butterfly_net;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        mode;
    logic [7:0]  mod;
    logic [31:0] omegas;
    logic [63:0] data_in;
    logic        out_valid;
    logic [63:0] data_out;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] d;
        int          due;
    } sb_t;

    sb_t         sb[$];
    logic [63:0] last_exp = '0;

    ntt_butterfly_net #(.DATA_W(8), .NUM_LANES(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .mode     (mode),
        .mod      (mod),
        .omegas   (omegas),
        .data_in  (data_in),
        .out_valid(out_valid),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    // Free-running edge counter used for latency bookkeeping.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] lanes8(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
        return {8'(a7), 8'(a6), 8'(a5), 8'(a4), 8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endfunction

    function automatic int pw(input int b, input int e, input int q);
        int r = 1;
        for (int i = 0; i < e; i++) r = (r * b) % q;
        return r;
    endfunction

    // Primitive 8th root of unity: r^4 == -1 mod q.
    function automatic int find_root(input int q);
        for (int r = 2; r < q; r++) if (pw(r, 4, q) == q - 1) return r;
        return 1;
    endfunction

    function automatic int rev3(input int i);
        return ((i & 1) << 2) | (i & 2) | ((i >> 2) & 1);
    endfunction

    function automatic int rev2(input int i);
        return ((i & 1) << 1) | ((i >> 1) & 1);
    endfunction

    // Direct-definition NTT of the bit-reversed input vector.
    function automatic logic [63:0] ntt_ref(input logic m, input int q, input int r, input logic [63:0] din);
        int x[8];
        int y[8];
        int acc;
        int r2;
        logic [63:0] o;
        if (!m) begin
            for (int i = 0; i < 8; i++) x[rev3(i)] = int'(din[8*i +: 8]);
            for (int k = 0; k < 8; k++) begin
                acc = 0;
                for (int j = 0; j < 8; j++) acc = (acc + x[j] * pw(r, j * k, q)) % q;
                y[k] = acc;
            end
        end else begin
            r2 = (r * r) % q;
            for (int h = 0; h < 2; h++) begin
                for (int i = 0; i < 4; i++) x[4*h + rev2(i)] = int'(din[8*(4*h+i) +: 8]);
                for (int k = 0; k < 4; k++) begin
                    acc = 0;
                    for (int j = 0; j < 4; j++) acc = (acc + x[4*h+j] * pw(r2, j * k, q)) % q;
                    y[4*h+k] = acc;
                end
            end
        end
        o = '0;
        for (int i = 0; i < 8; i++) o[8*i +: 8] = 8'(y[i]);
        return o;
    endfunction

    task automatic drive(input logic m, input logic [7:0] q, input logic [31:0] w,
                         input logic [63:0] d, input logic [63:0] exp);
        sb_t e;
        @(negedge clk);
        in_valid = 1'b1;
        mode     = m;
        mod      = q;
        omegas   = w;
        data_in  = d;
        e.d      = exp;
        e.due    = cyc + 3;
        sb.push_back(e);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        mode     = 1'($urandom_range(0, 1));
        mod      = 8'($urandom);
        omegas   = 32'($urandom);
        data_in  = {32'($urandom), 32'($urandom)};
    endtask

    task automatic drive_random();
        int q_tab[9] = '{17, 41, 73, 89, 97, 113, 193, 233, 241};
        int q;
        int r;
        logic m;
        logic [63:0] d;
        q = q_tab[$urandom_range(0, 8)];
        r = find_root(q);
        m = 1'($urandom_range(0, 1));
        for (int i = 0; i < 8; i++) d[8*i +: 8] = 8'($urandom_range(0, q - 1));
        drive(m, 8'(q), {8'(pw(r, 3, q)), 8'(pw(r, 2, q)), 8'(r), 8'd1}, d, ntt_ref(m, q, r, d));
    endtask

    // Output monitor: valid timing, data on valid, hold when idle.
    always @(negedge clk) begin
        logic exp_v;
        sb_t  e;
        if (!rst_n) begin
            last_exp = '0;
        end else begin
            if (sb.size() > 0 && sb[0].due < cyc) void'(sb.pop_front());
            exp_v = (sb.size() > 0) && (sb[0].due == cyc);
            check("out_valid", 64'(out_valid), 64'(exp_v));
            if (out_valid && exp_v) begin
                e = sb.pop_front();
                check("data_out", data_out, e.d);
                last_exp = e.d;
            end else if (!out_valid) begin
                check("hold", data_out, last_exp);
            end
        end
    end

    initial begin
        logic [63:0] v_d;
        logic [31:0] v_w;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        mode     = 1'b0;
        mod      = '0;
        omegas   = '0;
        data_in  = '0;
        #3 rst_n = 1'b0;
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_data", data_out, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        v_d = lanes8(0, 4, 2, 6, 1, 5, 3, 7);
        v_w = {8'd15, 8'd13, 8'd9, 8'd1};
        drive(1'b0, 8'd29, v_w, v_d, lanes8(28, 20, 2, 14, 25, 13, 19, 24));
        repeat (4) idle();
        drive(1'b1, 8'd29, v_w, v_d, lanes8(12, 2, 25, 19, 16, 2, 25, 19));
        repeat (4) idle();
        drive(1'b1, 8'd29, {8'd5, 8'd1, 8'd5, 8'd1}, lanes8(28, 28, 28, 28, 28, 28, 28, 28),
              lanes8(25, 0, 0, 0, 25, 0, 0, 0));
        repeat (2) idle();

        // Back-to-back with different modes.
        drive(1'b0, 8'd29, v_w, v_d, lanes8(28, 20, 2, 14, 25, 13, 19, 24));
        drive(1'b1, 8'd29, v_w, v_d, lanes8(12, 2, 25, 19, 16, 2, 25, 19));
        repeat (4) idle();

        // Degenerate moduli.
        drive(1'b0, 8'd1, 32'($urandom), {32'($urandom), 32'($urandom)}, 64'd0);
        drive(1'b1, 8'd0, 32'($urandom), {32'($urandom), 32'($urandom)}, 64'd0);
        repeat (4) idle();

        for (int n = 0; n < 40; n++) begin
            drive_random();
            if ($urandom_range(0, 2) == 0) idle();
        end
        repeat (4) idle();

        // Reset with three samples in flight.
        drive_random();
        drive_random();
        drive_random();
        @(posedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_valid", 64'(out_valid), 64'd0);
        check("rst_mid_data", data_out, 64'd0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        drive_random();
        repeat (5) idle();
        for (int n = 0; n < 8; n++) drive_random();
        repeat (2) idle();

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        check("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ntt_butterfly_net.md
Name: ntt_butterfly_net

Overview:
- Pipelined radix-2 decimation-in-time NTT butterfly network over Z_q.
- Operates either as one 8-point transform or as two independent 4-point transforms (lanes 0-3 and 4-7).
- Inputs arrive in bit-reversed order; outputs leave in natural order.
- Used as the transform core of the NTT datapath, fed by the bit-reversal/load stage.

Parameters:
- DATA_W, 8, width of each coefficient, twiddle and modulus.
- NUM_LANES, 8, number of coefficients per transform (fixed at 8).

Ports:
- clk  input  1  system clock, all registers rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  data_in/omegas/mod/mode are accepted this cycle.
- mode  input  1  0 = single 8-point transform; 1 = dual 4-point transforms.
- mod  input  DATA_W  modulus q.
- omegas  input  4*DATA_W  twiddles w[k] at bits [DATA_W*k +: DATA_W], k=0..3. w[k] = omega^k for the 8-point root.
- data_in  input  8*DATA_W  lane i at bits [DATA_W*i +: DATA_W], bit-reversed order.
- out_valid  output  1  data_out holds a result.
- data_out  output  8*DATA_W  lane i at bits [DATA_W*i +: DATA_W], natural order.

Behaviour:
- Butterfly(a,b,w):
  - t = (w*b) mod q, using the full 2*DATA_W product.
  - a' = (a+t) mod q; b' = (a-t) mod q.
  - Sum and difference are computed at DATA_W+1 bits, corrected by a single conditional subtract or add of q.
- Stage 1: pairs (0,1),(2,3),(4,5),(6,7), all with w[0].
- Stage 2: pairs (0,2),(4,6) with w[0]; pairs (1,3),(5,7) with w[2].
- Stage 3 (mode 0): pairs (i,i+4) with w[i], i=0..3.
- Stage 3 (mode 1): bypass, lanes pass unchanged. Output is two 4-point NTTs using twiddles w[0], w[2].
- Pipeline registers:
  - One register stage after each butterfly stage; latency is 3 cycles in both modes.
  - mod, omegas and mode are captured with data and travel down the pipeline with it. A change on these inputs affects only later samples.
- Throughput: one transform per cycle. No backpressure.
- out_valid is in_valid delayed by 3 cycles. data_out holds its value when out_valid=0 (no clearing between samples).
- Operand precondition: every data_in lane and twiddle is < q, and q >= 2. For out-of-range operands the output is reduced mod q but otherwise unspecified.
- mod = 0 or 1: every butterfly output is forced to 0 (no division by zero). out_valid still asserts normally.
- Reset (async, rst_n=0):
  - out_valid=0, data_out=0, all pipeline data/valid registers cleared immediately.
  - Samples in flight are discarded.
  - First accept is on the first rising edge after rst_n deasserts with in_valid=1.

Test Plan:
- Reset: assert rst_n=0 mid-stream with 3 samples in flight -> out_valid=0 and data_out=0 immediately. No stale sample ever appears after release.
- 8-point: q=29, omegas=[1,9,13,15], data_in=[0,4,2,6,1,5,3,7], mode=0, one in_valid pulse -> 3 cycles later out_valid=1, data_out=[28,20,2,14,25,13,19,24].
- Dual 4-point: same q/omegas/data, mode=1 -> data_out=[12,2,25,19,16,2,25,19]. Lanes 0-3 equal a standalone 4-point NTT of [0,4,2,6] with twiddles [1,13].
- Wrap-around: q=29, mode=1, all data=28, omegas=[1,x,1,x] -> data_out=[25,0,0,0,25,0,0,0].
- Back-to-back: the 8-point vector (mode 0) then the dual-4 vector (mode 1) on consecutive cycles -> results on consecutive cycles, each matching its own mode and parameters.
- Degenerate modulus: mod=1 with any data -> data_out all 0, out_valid pulses after 3 cycles.
